// File: rtl/aes256_unroll_batch_ctrl.sv
// ---------------------------------------------------------------------------
// aes256_unroll_batch_ctrl
//
// Batch sequencer for a STAGES-deep pipelined AES-256 round datapath. That
// datapath has no stall and no valid. Each block makes two passes through the
// datapath. Pass 1 uses key_set1 (rounds 1-7) and pass 2 uses key_set2
// (rounds 8-14). Up to BATCH_MAX blocks share a pass, so the key bus only
// changes between passes, when the pipeline is empty.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/ready    upstream handshake; in_data is already whitened with
//   in_data, in_last  round key 0, and in_last closes the batch
//   inv_req           decrypt request, taken with the first block of a batch
//   out_valid/ready   downstream handshake; out_last marks the last result
//   out_data
//   key_set1/2        per-pass round keys, stage-1 key in the MSBs
//   dp_input_text     datapath input mux
//   dp_round_key      datapath key bus
//   dp_inv_en         datapath direction
//   dp_output_text    datapath result
//   busy              low only when idle (FILL with an empty batch)
//
// Optional feature: define AES_BATCH_PERF_CNT_EN to add the free-running
// perf_batches / perf_blocks handshake counters.
// ---------------------------------------------------------------------------
module aes256_unroll_batch_ctrl #(
  parameter int BLOCK     = 128,
  parameter int STAGES    = 7,
  parameter int BATCH_MAX = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK-1:0]        in_data,
  input  logic                    in_last,
  input  logic                    inv_req,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK-1:0]        out_data,
  output logic                    out_last,
  input  logic [BLOCK*STAGES-1:0] key_set1,
  input  logic [BLOCK*STAGES-1:0] key_set2,
  output logic [BLOCK-1:0]        dp_input_text,
  output logic [BLOCK*STAGES-1:0] dp_round_key,
  output logic                    dp_inv_en,
  input  logic [BLOCK-1:0]        dp_output_text,
  output logic                    busy
`ifdef AES_BATCH_PERF_CNT_EN
  ,
  output logic [31:0]             perf_batches,
  output logic [31:0]             perf_blocks
`endif
);

  // Counters hold 0..BATCH_MAX; buffer pointers only need 0..BATCH_MAX-1.
  localparam int CW = $clog2(BATCH_MAX + 1);
  localparam int PW = (BATCH_MAX > 1) ? $clog2(BATCH_MAX) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BATCH_MAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    FILL,
    P1_WAIT,
    P2_ISSUE,
    P2_WAIT,
    DRAIN
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     wr;
  logic [CW-1:0]     rd;
  logic [STAGES-1:0] vld;
  logic              inv_q;
  logic [BLOCK-1:0]  res_buf [2**PW];

  logic accept;
  logic inject;
  logic capture;
  logic rd_is_last;

  assign accept     = (state == FILL) && in_valid && in_ready;
  assign inject     = accept || (state == P2_ISSUE);
  assign capture    = vld[STAGES-1];
  // rd is shared: pass-2 issue pointer in P2_ISSUE, output pointer in DRAIN.
  assign rd_is_last = (rd == (cnt - CNT_ONE));

  assign in_ready      = (state == FILL) && (cnt < CNT_MAX);
  assign dp_input_text = accept              ? in_data :
                         (state == P2_ISSUE) ? res_buf[rd[PW-1:0]] : '0;
  assign dp_round_key  = ((state == P2_ISSUE) || (state == P2_WAIT)) ? key_set2 : key_set1;
  // Direction follows the request until the batch opens, then stays latched.
  assign dp_inv_en     = ((state == FILL) && (cnt == '0)) ? inv_req : inv_q;
  assign busy          = !((state == FILL) && (cnt == '0));
  assign out_data      = out_valid ? res_buf[rd[PW-1:0]] : '0;
  assign out_last      = out_valid && rd_is_last;

  // Datapath results land in arrival order; pass 2 overwrites each entry only
  // after that entry has been re-issued.
  always_ff @(posedge clk) begin
    if (capture) res_buf[wr[PW-1:0]] <= dp_output_text;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      cnt       <= '0;
      wr        <= '0;
      rd        <= '0;
      vld       <= '0;
      inv_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // vld mirrors occupancy of the datapath stages.
      vld <= {vld[STAGES-2:0], inject};
      if (capture) wr <= wr + CNT_ONE;

      case (state)
        FILL: begin
          if (accept) begin
            cnt <= cnt + CNT_ONE;
            if (cnt == '0) inv_q <= inv_req;
            if (in_last || ((cnt + CNT_ONE) == CNT_MAX)) state <= P1_WAIT;
          end
        end
        P1_WAIT: begin
          // The key bus may only switch once the pipeline is empty.
          if ((wr == cnt) && (vld == '0)) begin
            wr    <= '0;
            rd    <= '0;
            state <= P2_ISSUE;
          end
        end
        P2_ISSUE: begin
          if (rd_is_last) begin
            rd    <= '0;
            state <= P2_WAIT;
          end else begin
            rd <= rd + CNT_ONE;
          end
        end
        P2_WAIT: begin
          // Leaving on the last capture means vld is already empty in DRAIN.
          if (capture && (wr == (cnt - CNT_ONE))) begin
            state     <= DRAIN;
            out_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_is_last) begin
              cnt       <= '0;
              wr        <= '0;
              rd        <= '0;
              out_valid <= 1'b0;
              state     <= FILL;
            end else begin
              rd <= rd + CNT_ONE;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef AES_BATCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_batches <= '0;
      perf_blocks  <= '0;
    end else if (out_valid && out_ready) begin
      perf_blocks <= perf_blocks + 32'd1;
      if (rd_is_last) perf_batches <= perf_batches + 32'd1;
    end
  end
`endif

endmodule
